// File: rtl/line_pkg.sv
// Shared definitions for the line pair scheduler.
//   WORD_W_DEF : default word width in bits
//   sched_st_t : scheduler FSM states
//   src_t      : requester index (0 or 1)
package line_pkg;

   localparam int WORD_W_DEF = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } sched_st_t;

   typedef logic src_t;

endpackage

// File: rtl/line_rr_arb.sv
// Two-way request arbiter for the line pair scheduler.
// Optional macro: LINE_SCHED_PRIO_EN -- when defined, requester 0 always
// wins ties and last_src is ignored; otherwise ties go round-robin.
// Ports:
//   req[1:0]  in   request vector, bit i = requester i
//   en        in   grant slot open this cycle
//   last_src  in   source of the most recent grant
//   gnt[1:0]  out  one-hot grant (zero when en=0 or no request)
//   src       out  index of the granted requester
module line_rr_arb
   import line_pkg::*;
(
   input  logic [1:0] req,
   input  logic       en,
   input  src_t       last_src,
   output logic [1:0] gnt,
   output src_t       src
);

`ifdef LINE_SCHED_PRIO_EN
   logic unused_last_src;
   assign unused_last_src = last_src;
`endif

   always_comb begin
      gnt = 2'b00;
      src = 1'b0;
      if (en) begin
         unique case (req)
            2'b01:   src = 1'b0;
            2'b10:   src = 1'b1;
`ifdef LINE_SCHED_PRIO_EN
            2'b11:   src = 1'b0;
`else
            // tie: the side that did not win last time goes now
            2'b11:   src = ~last_src;
`endif
            default: src = 1'b0;
         endcase
         if (req != 2'b00)
            gnt = src ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/line_pair_sched.sv
// Word-to-pair scheduler in front of line_data. Arbitrates between two
// word requesters, latches the winning word and shifts it out LSB-first
// one bit pair per clock (a_out = bit 2k, b_out = bit 2k+1).
// Optional macro: LINE_SCHED_PRIO_EN (fixed priority to requester 0,
// handled inside line_rr_arb).
//
// state | meaning
// IDLE  | no word in flight; every cycle is a grant slot
// SHIFT | presenting pair cnt of the latched word; last pair is a grant slot
//
// Ports:
//   clk        in   clock, posedge
//   clr        in   asynchronous active-low reset
//   req0/1     in   requester has a word ready (held until its gnt)
//   data0/1    in   requester word
//   gnt0/1     out  combinational grant pulse; data captured this edge
//   a_out      out  even bit of current pair
//   b_out      out  odd bit of current pair
//   pair_vld   out  a_out/b_out valid this cycle
//   cur_src    out  source of the word being shifted (holds when idle)
//   word_done  out  last pair of the word presented this cycle
module line_pair_sched
   import line_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
)
(
   input  logic              clk,
   input  logic              clr,
   input  logic              req0,
   input  logic [WORD_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [WORD_W-1:0] data1,
   output logic              gnt1,
   output logic              a_out,
   output logic              b_out,
   output logic              pair_vld,
   output logic              cur_src,
   output logic              word_done
);

   localparam int NP    = WORD_W / 2;
   localparam int CNT_W = $clog2(NP);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NP - 1);

   sched_st_t         state;
   sched_st_t         nxt_state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   src_t              last_src;
   src_t              cur_src_q;
   logic              slot;
   logic              last_pair;
   logic              granted;
   logic [1:0]        gnt_v;
   src_t              src_g;

   assign last_pair = (state == SHIFT) && (cnt == LAST);
   assign slot      = (state == IDLE) || last_pair;
   assign granted   = |gnt_v;

   line_rr_arb u_arb (
      .req      ({req1, req0}),
      .en       (slot),
      .last_src (last_src),
      .gnt      (gnt_v),
      .src      (src_g)
   );

   // state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= nxt_state;
   end

   // next state
   always_comb begin
      nxt_state = state;
      unique case (state)
         IDLE:    if (granted) nxt_state = SHIFT;
         SHIFT:   if (last_pair && !granted) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      gnt0      = gnt_v[0];
      gnt1      = gnt_v[1];
      pair_vld  = (state == SHIFT);
      a_out     = (state == SHIFT) & shreg[0];
      b_out     = (state == SHIFT) & shreg[1];
      cur_src   = cur_src_q;
      word_done = last_pair;
   end

   // datapath: a grant in the last-pair cycle reloads directly, giving
   // zero bubble between consecutive words
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         shreg     <= '0;
         cnt       <= '0;
         last_src  <= 1'b1;
         cur_src_q <= 1'b0;
      end else if (granted) begin
         shreg     <= src_g ? data1 : data0;
         cnt       <= '0;
         last_src  <= src_g;
         cur_src_q <= src_g;
      end else if (state == SHIFT) begin
         shreg <= shreg >> 2;
         cnt   <= last_pair ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_line_pair_sched.sv
module tb_line_pair_sched;
   import line_pkg::*;

   localparam int W  = 32;
   localparam int NP = W / 2;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] data0 = '0;
   logic [W-1:0] data1 = '0;
   logic         gnt0, gnt1, a_out, b_out, pair_vld, cur_src, word_done;

   int   total = 0;
   int   bad   = 0;
   logic last_m = 1'b1;
   bit   hold_reqs = 1'b0;
   logic s, nv, ns;

   line_pair_sched #(.WORD_W(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .req0      (req0),
      .data0     (data0),
      .gnt0      (gnt0),
      .req1      (req1),
      .data1     (data1),
      .gnt1      (gnt1),
      .a_out     (a_out),
      .b_out     (b_out),
      .pair_vld  (pair_vld),
      .cur_src   (cur_src),
      .word_done (word_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] arb_m(input logic r0, input logic r1, input logic last);
`ifdef LINE_SCHED_PRIO_EN
      if (r0) return 2'b01;
      if (r1) return 2'b10;
      return 2'b00;
`else
      if (r0 && r1) return last ? 2'b01 : 2'b10;
      if (r0) return 2'b01;
      if (r1) return 2'b10;
      return 2'b00;
`endif
   endfunction

   task automatic rst_chk(input string tag);
      chk({tag, "_gnt0"}, gnt0, 0);
      chk({tag, "_gnt1"}, gnt1, 0);
      chk({tag, "_a"}, a_out, 0);
      chk({tag, "_b"}, b_out, 0);
      chk({tag, "_vld"}, pair_vld, 0);
      chk({tag, "_src"}, cur_src, 0);
      chk({tag, "_done"}, word_done, 0);
   endtask

   task automatic drop_granted(input logic [1:0] g);
      if (!hold_reqs) begin
         if (g[0]) req0 = 1'b0;
         if (g[1]) req1 = 1'b0;
      end
   endtask

   // grant from IDLE; inputs already driven for this cycle
   task automatic idle_grant(output logic src);
      logic [1:0] e;
      @(negedge clk);
      e = arb_m(req0, req1, last_m);
      chk("idle_gnt0", gnt0, e[0]);
      chk("idle_gnt1", gnt1, e[1]);
      chk("idle_vld", pair_vld, 0);
      chk("idle_done", word_done, 0);
      @(posedge clk); #1;
      src = e[1];
      if (e != 2'b00) last_m = e[1];
      drop_granted(e);
   endtask

   // one full word from src sw; optionally raises requests at pair raise_k
   task automatic run_word(input logic sw, input int raise_k, input logic [1:0] raise_m,
                           output logic nxt_v, output logic nxt_s);
      logic [W-1:0] d;
      logic [1:0]   e;
      d = sw ? data1 : data0;
      nxt_v = 1'b0;
      nxt_s = 1'b0;
      for (int k = 0; k < NP; k++) begin
         if (k == raise_k) begin
            if (raise_m[0]) req0 = 1'b1;
            if (raise_m[1]) req1 = 1'b1;
         end
         @(negedge clk);
         chk("pair_vld", pair_vld, 1);
         chk("pair_a", a_out, d[2*k]);
         chk("pair_b", b_out, d[2*k+1]);
         chk("pair_src", cur_src, sw);
         chk("word_done", word_done, (k == NP-1) ? 1 : 0);
         e = (k == NP-1) ? arb_m(req0, req1, last_m) : 2'b00;
         chk("pair_gnt0", gnt0, e[0]);
         chk("pair_gnt1", gnt1, e[1]);
         @(posedge clk); #1;
         if (k == NP-1) begin
            nxt_v = |e;
            nxt_s = e[1];
            if (nxt_v) last_m = e[1];
            drop_granted(e);
         end
      end
   endtask

   task automatic idle_check(input int n, input logic src);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("gap_vld", pair_vld, 0);
         chk("gap_a", a_out, 0);
         chk("gap_b", b_out, 0);
         chk("gap_gnt0", gnt0, 0);
         chk("gap_gnt1", gnt1, 0);
         chk("gap_done", word_done, 0);
         chk("gap_src", cur_src, src);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      clr = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      #1 rst_chk("rst");
      last_m = 1'b1;
      @(negedge clk); #2;
      clr = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      // reset state
      #2 rst_chk("por");
      #20 clr = 1'b1;
      @(posedge clk); #1;

      // single word from IDLE
      data0 = 32'h3735_3AF2;
      req0  = 1'b1;
      idle_grant(s);
      chk("t1_src", s, 0);
      run_word(s, -1, 2'b00, nv, ns);
      chk("t1_next", nv, 0);
      idle_check(3, 1'b0);

`ifndef LINE_SCHED_PRIO_EN
      // ties go round-robin, back-to-back with no bubble
      do_reset();
      data0 = 32'hA0B1_C2D3;
      data1 = 32'h5C3E_91B7;
      req0 = 1'b1;
      req1 = 1'b1;
      idle_grant(s);
      chk("t2_first", s, 0);
      run_word(s, 3, 2'b01, nv, ns);
      chk("t2_v1", nv, 1);
      chk("t2_s1", ns, 1);
      run_word(ns, 2, 2'b10, nv, ns);
      chk("t2_v2", nv, 1);
      chk("t2_s2", ns, 0);
      run_word(ns, -1, 2'b00, nv, ns);
      chk("t2_v3", nv, 1);
      chk("t2_s3", ns, 1);
      run_word(ns, -1, 2'b00, nv, ns);
      chk("t2_end", nv, 0);
`else
      // fixed priority: both held, requester 0 always wins
      do_reset();
      hold_reqs = 1'b1;
      data0 = 32'h1234_5678;
      data1 = 32'hFEDC_BA98;
      req0 = 1'b1;
      req1 = 1'b1;
      idle_grant(s);
      chk("t3_first", s, 0);
      for (int i = 0; i < 3; i++) begin
         run_word(s, -1, 2'b00, nv, s);
         chk("t3_v", nv, 1);
         chk("t3_s", s, 0);
      end
      hold_reqs = 1'b0;
      do_reset();
`endif

      // late request waits for the last-pair slot
      data0 = 32'h0F0F_C3A5;
      data1 = 32'h9966_E187;
      req0  = 1'b1;
      idle_grant(s);
      chk("t4_src", s, 0);
      run_word(s, 5, 2'b10, nv, ns);
      chk("t4_v", nv, 1);
      chk("t4_s", ns, 1);
      run_word(ns, -1, 2'b00, nv, ns);
      chk("t4_end", nv, 0);

      // reset mid-word
      data0 = 32'hDEAD_BEEF;
      req0  = 1'b1;
      idle_grant(s);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("t5_a", a_out, data0[2*k]);
         chk("t5_b", b_out, data0[2*k+1]);
         @(posedge clk); #1;
      end
      #2 clr = 1'b0;
      #1 rst_chk("t5_async");
      @(negedge clk);
      rst_chk("t5_hold");
      #3 clr = 1'b1;
      last_m = 1'b1;
      @(posedge clk); #1;
      data0 = 32'h6B2D_4E19;
      req0  = 1'b1;
      idle_grant(s);
      chk("t5_src", s, 0);
      run_word(s, -1, 2'b00, nv, ns);
      chk("t5_end", nv, 0);

      // idle gap then a request granted in the cycle it rises
      idle_check(4, 1'b0);
      data1 = 32'h8421_7BDE;
      req1  = 1'b1;
      idle_grant(s);
      chk("t6_src", s, 1);
      run_word(s, -1, 2'b00, nv, ns);
      chk("t6_end", nv, 0);
      idle_check(2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
